skolem_lshr_ne_checker: RTL

Sequential checker for witnesses of the 4-bit invertibility condition "(x >> s) != t" with logical shift right. It accepts a (s, t, x) triple from an upstream Skolem-function block or a sweep driver, evaluates x >> s serially, and reports whether the constraint holds and whether a solution must exist. It keeps saturating check and failure counters, so it can close the loop on generated Skolem functions in exhaustive sweeps.

---
 rtl/skolem_chk_pkg.sv | 20 ++
 rtl/skolem_lshr_ne_checker_if.sv | 28 ++
 rtl/skolem_lshr_ne_checker_sat_counter.sv | 28 ++
 rtl/skolem_lshr_ne_checker.sv | 122 ++++++++++++
 4 files changed

// File: rtl/skolem_chk_pkg.sv
// Shared definitions for the Skolem witness checkers: FSM state type,
// default widths and the invertibility condition for (x >> s) != t.
package skolem_chk_pkg;

  localparam int W_DEF  = 4;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } chk_state_t;

  // A solution exists unless every x is shifted to zero and zero is forbidden.
  function automatic logic ic_lshr_ne(input logic [31:0] s, input logic [31:0] t,
                                      input int unsigned w);
    return !((s >= w) && (t == 32'd0));
  endfunction

endpackage

// File: rtl/skolem_lshr_ne_checker_if.sv
// Triple-in / verdict-out handshake bundle of the lshr-ne witness checker.
interface skolem_lshr_ne_checker_if
  import skolem_chk_pkg::*;
#(
  parameter int W = W_DEF
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_s;
  logic [W-1:0] in_t;
  logic [W-1:0] in_x;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_lshr;
  logic         out_holds;
  logic         out_ic;
  logic         out_fail;

  modport master (
    output in_valid, in_s, in_t, in_x, out_ready,
    input  in_ready, out_valid, out_lshr, out_holds, out_ic, out_fail
  );

  modport slave (
    input  in_valid, in_s, in_t, in_x, out_ready,
    output in_ready, out_valid, out_lshr, out_holds, out_ic, out_fail
  );
endinterface

// File: rtl/skolem_lshr_ne_checker_sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module sat_counter
  import skolem_chk_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt
);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/skolem_lshr_ne_checker.sv
// Serial checker for witnesses of (x >> s) != t: shifts x one bit per cycle,
// registers the verdict and keeps saturating check/failure counters.
module skolem_lshr_ne_checker
  import skolem_chk_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  skolem_lshr_ne_checker_if.slave  bus,
  output logic [CW-1:0]            chk_cnt,
  output logic [CW-1:0]            fail_cnt,
  input  logic                     clr_cnt
);

  localparam int CNTW = $clog2(W + 1);

  chk_state_t      state_q, state_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [W-1:0]    t_q, t_d;
  logic [CNTW-1:0] cnt_q, amt;
  logic [31:0]     s_ext;
  logic            ic_q, ic_d, holds_q, fail_q;
  logic            accept, shift_en, enter_done, done_hs;

  // Shift amounts at or beyond W all collapse to W, bounding the latency.
  assign s_ext = 32'(bus.in_s);
  assign amt   = (s_ext >= 32'(W)) ? CNTW'(W) : CNTW'(s_ext);

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    shift_en   = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept = 1'b1;
          if (amt == CNTW'(0)) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt_q == CNTW'(1)) begin
          state_d    = DONE;
          enter_done = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign shreg_d = accept ? bus.in_x : (shreg_q >> 1);
  assign t_d     = accept ? bus.in_t : t_q;
  assign ic_d    = accept ? ic_lshr_ne(32'(bus.in_s), 32'(bus.in_t), W) : ic_q;

  // Verdict is computed from the value about to land in the shift register,
  // so the flags are registered on the same edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      t_q     <= '0;
      cnt_q   <= '0;
      ic_q    <= 1'b0;
      holds_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q <= amt;
        t_q   <= t_d;
        ic_q  <= ic_d;
      end else if (shift_en) begin
        cnt_q <= cnt_q - CNTW'(1);
      end
      if (accept || shift_en) shreg_q <= shreg_d;
      if (enter_done) begin
        holds_q <= (shreg_d != t_d);
        fail_q  <= ic_d & (shreg_d == t_d);
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_lshr  = shreg_q;
  assign bus.out_holds = holds_q;
  assign bus.out_ic    = ic_q;
  assign bus.out_fail  = fail_q;

  assign done_hs = (state_q == DONE) & bus.out_ready;

  sat_counter #(.CW(CW)) u_chk_cnt (
    .clk (clk),
    .rst (rst),
    .inc (done_hs),
    .clr (clr_cnt),
    .cnt (chk_cnt)
  );

  sat_counter #(.CW(CW)) u_fail_cnt (
    .clk (clk),
    .rst (rst),
    .inc (done_hs & fail_q),
    .clr (clr_cnt),
    .cnt (fail_cnt)
  );

endmodule
